if_stage_bp: RTL and testbench

- Instruction-fetch stage with a dynamic branch predictor and the IF/ID pipeline register.
- Owns the PC, drives the instruction-memory address, and predicts taken branches with a 2-bit BHT plus a direct-mapped BTB.
- Registers pc/instruction/prediction bit into the ID stage; the BP bit travels through the ID/EX register to EX.
- Takes stall from the hazard unit, and flush/redirect plus training updates from EX branch resolution.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/bp_table.sv | 55 +++++
 rtl/if_stage_bp.sv | 78 +++++++
 tb/tb_if_stage_bp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and helpers for the fetch-side branch predictor.
package rv_pkg;

  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ZERO_INSTR  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != ST) res = cnt + 2'd1;
    end else begin
      if (cnt != SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BHT + BTB with one lookup port and one training port.
module bp_table
  import rv_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  lookup_idx,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       bht        [ENTRIES];
  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];

  logic btb_hit;

  // Lookup reads pre-update contents; a same-cycle update shows up next cycle.
  assign btb_hit     = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
  assign pred_taken  = btb_hit && bht[lookup_idx][1];
  assign pred_target = btb_target[lookup_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i[IDX_W-1:0]]       <= WNT;
        btb_valid[i[IDX_W-1:0]] <= 1'b0;
      end
    end else if (upd_valid) begin
      bht[upd_idx] <= bht_next(bht[upd_idx], upd_taken);
      if (upd_taken) btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed behind btb_valid.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/if_stage_bp.sv
// Fetch stage: PC register, predicted next-PC selection and the IF/ID register.
module if_stage_bp
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter int          IDX_W    = 4,
  parameter int          TAG_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        BP_ID,
  output logic        valid_ID
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        unused_upd_pc_bits;

  assign imem_addr = pc_q;

  bp_table #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_bp_table (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (pc_q[IDX_W+1:2]),
    .lookup_tag (pc_q[IDX_W+TAG_W+1:IDX_W+2]),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_pc[IDX_W+1:2]),
    .upd_tag    (upd_pc[IDX_W+TAG_W+1:IDX_W+2]),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  assign unused_upd_pc_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

  assign next_pc = pred_taken ? pred_target : pc_q + 32'd4;

  // Flush beats stall: a mispredict must redirect even while ID is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pc_ID    <= 32'd0;
      instr_ID <= ZERO_INSTR;
      BP_ID    <= 1'b0;
      valid_ID <= 1'b0;
    end else if (flush) begin
      pc_q     <= redirect_pc;
      pc_ID    <= 32'd0;
      instr_ID <= ZERO_INSTR;
      BP_ID    <= 1'b0;
      valid_ID <= 1'b0;
    end else if (!stall) begin
      pc_q     <= next_pc;
      pc_ID    <= pc_q;
      instr_ID <= imem_rdata;
      BP_ID    <= pred_taken;
      valid_ID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_bp.sv
// Directed plus randomized bench for if_stage_bp against a table-level reference model.
module tb_if_stage_bp;

  logic        clk = 1'b0;
  logic        rst, stall, flush, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_ID, instr_ID;
  logic        BP_ID, valid_ID;
  logic        imem_mode;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_pc_id, m_instr_id;
  logic        m_bp_id, m_valid_id;
  int          m_bht   [16];
  bit          m_bv    [16];
  int          m_btag  [16];
  logic [31:0] m_btgt  [16];

  always #5 clk = ~clk;

  if_stage_bp dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .pc_ID      (pc_ID),
    .instr_ID   (instr_ID),
    .BP_ID      (BP_ID),
    .valid_ID   (valid_ID)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a, input logic mode);
    return mode ? {a[15:0] ^ 16'h5a5a, 16'h0013} : 32'h0000_0013;
  endfunction

  always_comb imem_rdata = memWord(imem_addr, imem_mode);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the specification's rules, using pre-update table contents for lookup.
  task automatic modelStep();
    int idx, tag, ui;
    bit pt;
    logic [31:0] npc;
    if (rst) begin
      m_pc = 32'h0; m_pc_id = 0; m_instr_id = 0; m_bp_id = 0; m_valid_id = 0;
      for (int i = 0; i < 16; i++) begin m_bht[i] = 1; m_bv[i] = 0; end
      return;
    end
    idx = (m_pc / 4) % 16;
    tag = (m_pc / 64) % 256;
    pt  = m_bv[idx] && (m_btag[idx] == tag) && (m_bht[idx] >= 2);
    npc = pt ? m_btgt[idx] : m_pc + 32'd4;
    if (flush) begin
      m_pc = redirect_pc; m_pc_id = 0; m_instr_id = 0; m_bp_id = 0; m_valid_id = 0;
    end else if (!stall) begin
      m_pc_id = m_pc; m_instr_id = memWord(m_pc, imem_mode);
      m_bp_id = pt; m_valid_id = 1; m_pc = npc;
    end
    if (upd_valid) begin
      ui = (upd_pc / 4) % 16;
      if (upd_taken) begin
        if (m_bht[ui] < 3) m_bht[ui]++;
        m_bv[ui] = 1; m_btag[ui] = (upd_pc / 64) % 256; m_btgt[ui] = upd_target;
      end else if (m_bht[ui] > 0) m_bht[ui]--;
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("pc_ID", pc_ID, m_pc_id);
    checkOutput("instr_ID", instr_ID, m_instr_id);
    checkOutput("BP_ID", {31'd0, BP_ID}, {31'd0, m_bp_id});
    checkOutput("valid_ID", {31'd0, valid_ID}, {31'd0, m_valid_id});
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic [31:0] rpc,
                               input logic uv, input logic [31:0] up, input logic ut,
                               input logic [31:0] utg);
    rst = r; stall = s; flush = f; redirect_pc = rpc;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirectTo(input logic [31:0] a);
    applyStimulus(0, 0, 1, a, 0, 0, 0, 0);
  endtask

  initial begin
    imem_mode = 0;
    rst = 1; stall = 0; flush = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'd0, valid_ID}, 32'd0);

    idle();
    checkOutput("first_valid", {31'd0, valid_ID}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h4);
    idle();
    checkOutput("seq_addr8", imem_addr, 32'h8);
    checkOutput("seq_bp", {31'd0, BP_ID}, 32'd0);

    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_addr", imem_addr, 32'h8);
    checkOutput("stall_pcid", pc_ID, 32'h4);
    idle();
    checkOutput("resume_pcid", pc_ID, 32'h8);
    checkOutput("resume_addr", imem_addr, 32'hc);

    applyStimulus(0, 1, 1, 32'h100, 0, 0, 0, 0);
    checkOutput("flush_addr", imem_addr, 32'h100);
    checkOutput("flush_valid", {31'd0, valid_ID}, 32'd0);
    idle();
    checkOutput("redir_pcid", pc_ID, 32'h100);
    checkOutput("redir_valid", {31'd0, valid_ID}, 32'd1);

    // Train 0x20 taken to 0x80 twice: counter 01 -> 10 -> 11
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 32'h20, 1, 32'h80);
    redirectTo(32'h20);
    idle();
    checkOutput("trained_bp", {31'd0, BP_ID}, 32'd1);
    checkOutput("trained_next", imem_addr, 32'h80);

    // Saturate down with four not-taken updates while stalled
    repeat (4) applyStimulus(0, 1, 0, 0, 1, 32'h20, 0, 32'h0);
    redirectTo(32'h20);
    idle();
    checkOutput("sat_bp", {31'd0, BP_ID}, 32'd0);
    checkOutput("sat_next", imem_addr, 32'h24);
    applyStimulus(0, 1, 0, 0, 1, 32'h20, 0, 32'h0);
    redirectTo(32'h20);
    idle();
    checkOutput("sat_floor_bp", {31'd0, BP_ID}, 32'd0);

    // Rebuild to weakly taken, then alias from 0x60 while 0x20 is looked up
    repeat (2) applyStimulus(0, 1, 0, 0, 1, 32'h20, 1, 32'h80);
    redirectTo(32'h20);
    applyStimulus(0, 0, 0, 0, 1, 32'h60, 1, 32'h200);
    checkOutput("alias_old_bp", {31'd0, BP_ID}, 32'd1);
    checkOutput("alias_old_next", imem_addr, 32'h80);
    redirectTo(32'h20);
    idle();
    checkOutput("alias_miss_bp", {31'd0, BP_ID}, 32'd0);
    checkOutput("alias_miss_next", imem_addr, 32'h24);

    // Randomized traffic with small address space to force aliasing and hits
    imem_mode = 1;
    for (int n = 0; n < 400; n++) begin
      logic r, s, f, uv, ut;
      logic [31:0] rpc, up, utg;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 9) == 0);
      uv  = ($urandom_range(0, 9) < 3);
      ut  = $urandom_range(0, 1) == 1;
      rpc = 32'($urandom_range(0, 127)) << 2;
      up  = 32'($urandom_range(0, 511)) << 2;
      utg = 32'($urandom_range(0, 127)) << 2;
      applyStimulus(r, s, f, rpc, uv, up, ut, utg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
